sram_port_arbiter: RTL and testbench

//  Shares one synchronous SRAM port between the IF stage (instruction reads) and the MEM stage (loads/stores).

---
 rtl/sram_port_arbiter.sv | 115 +++++++++++
 tb/tb_sram_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one synchronous SRAM port between IF reads and MEM loads/stores
// One access in flight; MEM has priority, but IF is forced a grant after STARVE_MAX conflicted MEM wins.
module sram_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_addr_ok,
  output logic        o_if_data_ok,
  output logic [31:0] o_if_rdata,
  input  logic        i_mem_req,
  input  logic        i_mem_wr,
  input  logic [3:0]  i_mem_wstrb,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic        o_mem_addr_ok,
  output logic        o_mem_data_ok,
  output logic [31:0] o_mem_rdata,
  output logic        o_sram_en,
  output logic [3:0]  o_sram_wen,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  input  logic [31:0] i_sram_rdata
);

  localparam logic [2:0] LP_RD_LAT     = 3'(RD_LAT);
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t     r_state, w_state_nxt;
  owner_t     r_owner, w_owner_nxt;
  logic [2:0] r_lat_cnt, w_lat_nxt;
  logic [3:0] r_starve_cnt, w_starve_nxt;
  logic       r_store, w_store_nxt;

  logic w_done, w_can_issue, w_both, w_grant_if, w_grant_mem;

  assign w_done      = (r_state == S_BUSY) && (r_lat_cnt == 3'd1);
  // Gating with rst_n keeps the request-driven outputs at 0 while reset is held.
  assign w_can_issue = rst_n && ((r_state == S_IDLE) || w_done);
  assign w_both      = i_if_req && i_mem_req;
  assign w_grant_if  = w_can_issue && i_if_req && (!i_mem_req || (r_starve_cnt == LP_STARVE_MAX));
  assign w_grant_mem = w_can_issue && i_mem_req && !w_grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
      r_store      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_store      <= w_store_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_lat_nxt    = r_lat_cnt;
    w_starve_nxt = r_starve_cnt;
    w_store_nxt  = r_store;
    if (w_grant_if || w_grant_mem) begin
      w_state_nxt = S_BUSY;
      w_owner_nxt = w_grant_if ? OWN_IF : OWN_MEM;
      w_lat_nxt   = LP_RD_LAT;
      w_store_nxt = w_grant_mem && i_mem_wr;
    end else if (w_done) begin
      w_state_nxt = S_IDLE;
      w_owner_nxt = OWN_NONE;
      w_lat_nxt   = 3'd0;
      w_store_nxt = 1'b0;
    end else if (r_state == S_BUSY) begin
      w_lat_nxt = r_lat_cnt - 3'd1;
    end
    // Starvation only accrues when IF actually lost a conflict.
    if (w_both && w_grant_mem && (r_starve_cnt < LP_STARVE_MAX)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end else if (w_both && w_grant_if) begin
      w_starve_nxt = 4'd0;
    end
  end

  always_comb begin
    o_if_addr_ok  = w_grant_if;
    o_mem_addr_ok = w_grant_mem;
    o_sram_en     = 1'b0;
    o_sram_wen    = 4'b0000;
    o_sram_addr   = 32'd0;
    o_sram_wdata  = 32'd0;
    if (w_grant_if) begin
      o_sram_en   = 1'b1;
      o_sram_addr = i_if_addr;
    end else if (w_grant_mem) begin
      o_sram_en    = 1'b1;
      o_sram_addr  = i_mem_addr;
      o_sram_wdata = i_mem_wdata;
      o_sram_wen   = i_mem_wr ? i_mem_wstrb : 4'b0000;
    end
    o_if_data_ok  = w_done && (r_owner == OWN_IF);
    o_mem_data_ok = w_done && (r_owner == OWN_MEM);
    o_if_rdata    = o_if_data_ok ? i_sram_rdata : 32'd0;
    o_mem_rdata   = (o_mem_data_ok && !r_store) ? i_sram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed bench for sram_port_arbiter
// dut_a runs with RD_LAT=1, dut_b with RD_LAT=3; both see the same requests, each has its own reset.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        if_req, mem_req, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        a_if_addr_ok, a_if_data_ok, a_mem_addr_ok, a_mem_data_ok, a_sram_en;
  logic [31:0] a_if_rdata, a_mem_rdata, a_sram_addr, a_sram_wdata, a_sram_rdata, a_last;
  logic [3:0]  a_sram_wen, a_hs;
  logic        b_if_addr_ok, b_if_data_ok, b_mem_addr_ok, b_mem_data_ok, b_sram_en;
  logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata, b_last;
  logic [3:0]  b_sram_wen, b_hs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // SRAM model: read data is the issued address + 0x1000, held until the next issue.
  initial begin a_last = 32'd0; b_last = 32'd0; end
  always @(posedge clk) begin
    if (a_sram_en) a_last <= a_sram_addr;
    if (b_sram_en) b_last <= b_sram_addr;
  end
  assign a_sram_rdata = a_last + 32'h1000;
  assign b_sram_rdata = b_last + 32'h1000;

  assign a_hs = {a_if_addr_ok, a_mem_addr_ok, a_if_data_ok, a_mem_data_ok};
  assign b_hs = {b_if_addr_ok, b_mem_addr_ok, b_if_data_ok, b_mem_data_ok};

  sram_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_addr_ok(a_if_addr_ok), .o_if_data_ok(a_if_data_ok), .o_if_rdata(a_if_rdata),
    .i_mem_req(mem_req), .i_mem_wr(mem_wr), .i_mem_wstrb(mem_wstrb),
    .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_addr_ok(a_mem_addr_ok), .o_mem_data_ok(a_mem_data_ok), .o_mem_rdata(a_mem_rdata),
    .o_sram_en(a_sram_en), .o_sram_wen(a_sram_wen), .o_sram_addr(a_sram_addr),
    .o_sram_wdata(a_sram_wdata), .i_sram_rdata(a_sram_rdata)
  );

  sram_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_addr_ok(b_if_addr_ok), .o_if_data_ok(b_if_data_ok), .o_if_rdata(b_if_rdata),
    .i_mem_req(mem_req), .i_mem_wr(mem_wr), .i_mem_wstrb(mem_wstrb),
    .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_addr_ok(b_mem_addr_ok), .o_mem_data_ok(b_mem_data_ok), .o_mem_rdata(b_mem_rdata),
    .o_sram_en(b_sram_en), .o_sram_wen(b_sram_wen), .o_sram_addr(b_sram_addr),
    .o_sram_wdata(b_sram_wdata), .i_sram_rdata(b_sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [3:0] starve_exp [7];

  initial begin
    starve_exp = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b1001, 4'b0110, 4'b0101};
    rst_a = 1'b0; rst_b = 1'b0;
    if_req = 1'b1; mem_req = 1'b1; mem_wr = 1'b0; mem_wstrb = 4'b0;
    if_addr = 32'hBFC0_0000; mem_addr = 32'h0000_0200; mem_wdata = 32'd0;

    // Reset held with both requests high
    @(negedge clk); #1;
    chk("rst_hs", 32'(a_hs), 32'h0);
    chk("rst_sram_en", 32'(a_sram_en), 32'h0);
    chk("rst_sram_addr", a_sram_addr, 32'h0);
    chk("rst_sram_wen", 32'(a_sram_wen), 32'h0);
    chk("rst_if_rdata", a_if_rdata, 32'h0);
    chk("rst_mem_rdata", a_mem_rdata, 32'h0);

    // Release: MEM first, then starvation pattern M,M,M,M,I,M
    @(negedge clk); rst_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("starve_hs%0d", i), 32'(a_hs), 32'(starve_exp[i]));
      if (i == 0) chk("first_grant_addr", a_sram_addr, 32'h0000_0200);
      if (i == 1) chk("load_rdata", a_mem_rdata, 32'h0000_1200);
      if (i == 1) chk("load_if_rdata_zero", a_if_rdata, 32'h0);
      if (i == 4) chk("starve_cnt_max", 32'(dut_a.r_starve_cnt), 32'd4);
      if (i == 4) chk("forced_if_addr", a_sram_addr, 32'hBFC0_0000);
      if (i == 5) chk("starve_cnt_clear", 32'(dut_a.r_starve_cnt), 32'd0);
      if (i == 5) chk("forced_if_rdata", a_if_rdata, 32'hBFC0_1000);
      @(negedge clk);
    end

    // IF only stream, RD_LAT=1
    if_req = 1'b0; mem_req = 1'b0; #1;
    chk("drain_hs", 32'(a_hs), 32'b0001);
    @(negedge clk); if_req = 1'b1; #1;
    chk("if_only_hs0", 32'(a_hs), 32'b1000);
    chk("if_only_addr", a_sram_addr, 32'hBFC0_0000);
    @(negedge clk); #1;
    chk("if_only_hs1", 32'(a_hs), 32'b1010);
    chk("if_only_rdata", a_if_rdata, 32'hBFC0_1000);
    @(negedge clk); #1;
    chk("if_only_hs2", 32'(a_hs), 32'b1010);
    @(negedge clk); if_req = 1'b0; #1;
    chk("if_only_tail", 32'(a_hs), 32'b0010);

    // MEM store
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_wstrb = 4'b0011;
    mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF; #1;
    chk("store_hs", 32'(a_hs), 32'b0100);
    chk("store_wen", 32'(a_sram_wen), 32'b0011);
    chk("store_addr", a_sram_addr, 32'h0000_0100);
    chk("store_wdata", a_sram_wdata, 32'hDEAD_BEEF);
    @(negedge clk); mem_req = 1'b0; mem_wr = 1'b0; mem_wstrb = 4'b0; #1;
    chk("store_done_hs", 32'(a_hs), 32'b0001);
    chk("store_rdata_zero", a_mem_rdata, 32'h0);
    @(negedge clk); #1;
    chk("idle_hs", 32'(a_hs), 32'b0000);
    chk("idle_sram_en", 32'(a_sram_en), 32'h0);
    chk("idle_sram_wdata", a_sram_wdata, 32'h0);

    // RD_LAT=3, IF then MEM alternating
    @(negedge clk); rst_b = 1'b1; if_req = 1'b1; if_addr = 32'hBFC0_0010; #1;
    chk("lat3_if_grant", 32'(b_hs), 32'b1000);
    @(negedge clk); if_req = 1'b0; mem_req = 1'b1; mem_addr = 32'h0000_0300; #1;
    chk("lat3_wait0", 32'(b_hs), 32'b0000);
    @(negedge clk); #1;
    chk("lat3_wait1", 32'(b_hs), 32'b0000);
    @(negedge clk); #1;
    chk("lat3_if_done_mem_grant", 32'(b_hs), 32'b0110);
    chk("lat3_if_rdata", b_if_rdata, 32'hBFC0_1010);
    chk("lat3_mem_addr", b_sram_addr, 32'h0000_0300);
    @(negedge clk); mem_req = 1'b0; #1;
    chk("lat3_wait2", 32'(b_hs), 32'b0000);
    @(negedge clk); #1;
    chk("lat3_wait3", 32'(b_hs), 32'b0000);
    @(negedge clk); #1;
    chk("lat3_mem_done", 32'(b_hs), 32'b0001);
    chk("lat3_mem_rdata", b_mem_rdata, 32'h0000_1300);

    // Reset pulse while BUSY abandons the access
    @(negedge clk); if_req = 1'b1; if_addr = 32'hBFC0_0020; #1;
    chk("midrst_grant", 32'(b_hs), 32'b1000);
    @(negedge clk); if_req = 1'b0; #1;
    chk("midrst_busy", 32'(b_hs), 32'b0000);
    @(negedge clk); rst_b = 1'b0; if_req = 1'b1; #1;
    chk("midrst_held_hs", 32'(b_hs), 32'b0000);
    chk("midrst_held_en", 32'(b_sram_en), 32'h0);
    @(posedge clk); #1; rst_b = 1'b1; if_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("midrst_quiet%0d", i), 32'(b_hs), 32'b0000);
      @(negedge clk);
    end
    chk("midrst_state_idle", 32'(dut_b.r_state), 32'd0);
    if_req = 1'b1; if_addr = 32'hBFC0_0030; #1;
    chk("midrst_reissue", 32'(b_hs), 32'b1000);
    @(negedge clk); if_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("midrst_reissue_done", 32'(b_hs), 32'b0010);
    chk("midrst_reissue_rdata", b_if_rdata, 32'hBFC0_1030);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
